// File: rtl/cache_bus_axi_bridge.sv
// ============================================================================
// Module   : cache_bus_axi_bridge (with cache_bus_pkg)
// Brief    : Cache-bus responder that turns one request at a time into AXI4
//            AR/R read or AW/W/B write transactions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cache_bus_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  burst_size;
    logic        cached;
    logic [1:0]  data_size;
    logic [31:0] addr;
    logic        data_ok;
    logic        data_last;
    logic [3:0]  data_strobe;
    logic [31:0] w_data;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;

endpackage

module cache_bus_axi_bridge
  import cache_bus_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  cache_bus_req_t  bus_req_i,
  output cache_bus_resp_t bus_resp_o,
  output logic            bus_busy_o,
  output logic [3:0]      arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [3:0]      awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [3:0]      awcache,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    RADDR = 6'b000010,
    RDATA = 6'b000100,
    WADDR = 6'b001000,
    WDATA = 6'b010000,
    WRESP = 6'b100000
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [3:0]  cache_q;
  logic [3:0]  beat_cnt;
  logic        busy_q;
  logic        accept;
  logic        w_hs;
  logic        unused_req_last;

  // The initiator's own last flag is redundant: the beat counter decides wlast.
  assign unused_req_last = bus_req_i.data_last;

  assign accept = (state == IDLE) && bus_req_i.valid;
  assign w_hs   = (state == WDATA) && bus_req_i.data_ok && wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      cache_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
      if (accept) begin
        addr_q   <= bus_req_i.addr;
        len_q    <= {4'b0, bus_req_i.burst_size};
        size_q   <= {1'b0, bus_req_i.data_size};
        cache_q  <= bus_req_i.cached ? 4'b1111 : 4'b0000;
        beat_cnt <= bus_req_i.burst_size;
      end else if (w_hs && (beat_cnt != 4'd0)) begin
        beat_cnt <= beat_cnt - 4'd1;
      end
    end
  end

  assign bus_busy_o = busy_q;
  assign arid       = AXI_ID;
  assign awid       = AXI_ID;
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign arlen      = len_q;
  assign awlen      = len_q;
  assign arsize     = size_q;
  assign awsize     = size_q;
  assign arcache    = cache_q;
  assign awcache    = cache_q;
  assign arburst    = 2'b01;
  assign awburst    = 2'b01;

  always_comb begin
    next_state = state;
    bus_resp_o = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wlast      = 1'b0;
    bready     = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by reset so a request is never acknowledged on a cycle it cannot be latched.
        bus_resp_o.ready = bus_req_i.valid && rst_n;
        if (bus_req_i.valid) begin
          next_state = bus_req_i.write ? WADDR : RADDR;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) next_state = RDATA;
      end
      RDATA: begin
        rready               = bus_req_i.data_ok;
        bus_resp_o.data_ok   = rvalid && bus_req_i.data_ok;
        bus_resp_o.data_last = rlast && rvalid;
        bus_resp_o.r_data    = rdata;
        if (rvalid && bus_req_i.data_ok && rlast) next_state = IDLE;
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) next_state = WDATA;
      end
      WDATA: begin
        wvalid               = bus_req_i.data_ok;
        wdata                = bus_req_i.w_data;
        wstrb                = bus_req_i.data_strobe;
        wlast                = (beat_cnt == 4'd0);
        bus_resp_o.data_ok   = w_hs;
        bus_resp_o.data_last = w_hs && (beat_cnt == 4'd0);
        if (w_hs && (beat_cnt == 4'd0)) next_state = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

`default_nettype wire
